sdram_arbit: RTL
================

Name: sdram_arbit

Overview:
- Central arbiter of the SDRAM controller.
- Shares the single SDRAM command/address/data bus between the initialisation, auto-refresh, write and read sub-modules.
- Grants one requester at a time via level enables and waits for that requester's end pulse before releasing the bus.
- Muxes the granted requester's {CS#,RAS#,CAS#,WE#}, bank, address and write data onto the SDRAM pins.

Parameters:
- CNT_W, 10, width of the grant watchdog counter.
- MAX_GRANT, 10'd1000, cycles a grant may be held without an end pulse before forced release.

Ports:
- arb_clk  input  1  controller clock, 100 MHz.
- arb_rst  input  1  synchronous, active-high reset.
- init_end  input  1  initialisation complete; level, stays high once set.
- init_cmd/init_bank/init_addr  input  4/2/13  initialisation module bus.
- ar_req  input  1  auto-refresh request.
- ar_end  input  1  auto-refresh done, 1-cycle pulse.
- ar_cmd/ar_bank/ar_addr  input  4/2/13  auto-refresh module bus.
- wr_req, wr_end  input  1  write request; write done pulse.
- wr_cmd/wr_bank/wr_addr  input  4/2/13  write module bus.
- wr_dq_oe  input  1  write module drives DQ.
- wr_dq  input  16  write data.
- rd_req, rd_end  input  1  read request; read done pulse.
- rd_cmd/rd_bank/rd_addr  input  4/2/13  read module bus.
- ar_en, wr_en, rd_en  output  1  grant enables.
- sdram_cmd  output  4  {CS#,RAS#,CAS#,WE#}.
- sdram_ba  output  2  bank address.
- sdram_addr  output  13  SDRAM address.
- sdram_dq_oe  output  1  DQ output enable.
- sdram_dq_out  output  16  DQ write data.
- arb_timeout  output  1  1-cycle pulse on watchdog release.

Behaviour:
- Reset values (arb_rst high at a clock edge): state=INIT, last_wr=0, cnt_grant=0, all enables 0, arb_timeout=0.
- Idle bus value: sdram_cmd=4'b0111 (NOP), sdram_ba=2'b11, sdram_addr=13'h1fff, sdram_dq_oe=0, sdram_dq_out=0. This is the bus value in IDLE and whenever no requester is granted.
- Enables are decoded from the state register: ar_en=(AREF), wr_en=(WRITE), rd_en=(READ). No combinational path from any request input.
- Bus mux is combinational from the state register and adds 0 cycles latency. Sub-modules register their own outputs.
  - INIT: init_*.
  - AREF: ar_*.
  - WRITE: wr_*, and dq_oe/dq = wr_dq_oe/wr_dq.
  - READ: rd_*.
  - IDLE: NOP, ba=2'b11, addr=13'h1fff.
  - dq_oe=0 in every state except WRITE.
- FSM states: INIT, IDLE, AREF, WRITE, READ.
  - INIT -> IDLE when init_end=1.
  - IDLE grant priority:
    - ar_req -> AREF.
    - else wr_req & rd_req -> READ if last_wr=1, otherwise WRITE (round-robin between read and write).
    - else wr_req -> WRITE.
    - else rd_req -> READ.
    - else stay in IDLE.
  - AREF -> IDLE on ar_end.
  - WRITE -> IDLE on wr_end; last_wr<=1.
  - READ -> IDLE on rd_end; last_wr<=0.
- At least one IDLE cycle always separates two grants.
- An end pulse together with any new request returns the FSM to IDLE first; re-arbitration happens on the next cycle.
- Refresh is never pre-empted by the arbiter. A pending ar_req during WRITE/READ waits for wr_end/rd_end; the write and read modules terminate their bursts on ar_req themselves.
- End pulses for a requester that is not currently granted are ignored.
- Watchdog:
  - cnt_grant clears in INIT/IDLE and increments by 1 in AREF/WRITE/READ.
  - If cnt_grant==MAX_GRANT-1 with no end pulse that cycle: next state=IDLE, arb_timeout=1 for one cycle, cnt_grant cleared, last_wr not updated.
- init_end low in any state other than INIT: next state=INIT, all enables drop. This fail-safe takes priority over all other transitions.
- Reset asserted mid-grant: the state returns to INIT on that edge and enables drop the same cycle; the sub-modules are reset by the same signal.

Decomposition:
- Shared package holds:
  - command constants CMD_NOP=4'b0111, CMD_PRE=4'b0010, CMD_AR=4'b0001;
  - state encodings;
  - idle bank/address constants 2'b11 and 13'h1fff;
  - bus widths 4/2/13/16.
- No sub-module. The FSM, round-robin flag, watchdog and mux fit comfortably in one block.

Test Plan:
- Reset then init_end=0 for 20 cycles -> sdram_cmd follows init_cmd, all enables 0. init_end=1 -> IDLE next cycle, sdram_cmd=4'b0111.
- ar_req, wr_req and rd_req all high in IDLE -> ar_en=1 next cycle. After ar_end -> one IDLE cycle, then wr_en=1 (last_wr=0). After wr_end -> IDLE, then rd_en=1.
- WRITE granted with wr_dq_oe=1, wr_dq=16'hA5A5 -> sdram_dq_oe=1, sdram_dq_out=16'hA5A5. In READ -> sdram_dq_oe=0.
- ar_req raised mid-WRITE -> wr_en stays 1 until wr_end. Then IDLE for 1 cycle, then ar_en=1.
- Grant READ and never pulse rd_end -> rd_en drops after 1000 cycles, arb_timeout pulses once, next request is arbitrated normally.
- Drop init_end during AREF -> state INIT, ar_en=0, sdram_cmd follows init_cmd. Assert arb_rst mid-WRITE -> wr_en=0 on the following cycle.

Source files
------------

// File: rtl/sdram_arbit_pkg.sv
// ============================================================================
// Module      : sdram_arbit_pkg
// Description : Shared SDRAM bus constants, widths and arbiter state codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_arbit_pkg;

    localparam int CMD_W  = 4;
    localparam int BA_W   = 2;
    localparam int ADDR_W = 13;
    localparam int DQ_W   = 16;

    // {CS#,RAS#,CAS#,WE#}
    localparam logic [CMD_W-1:0]  CMD_NOP = 4'b0111;
    localparam logic [CMD_W-1:0]  CMD_PRE = 4'b0010;
    localparam logic [CMD_W-1:0]  CMD_AR  = 4'b0001;

    localparam logic [BA_W-1:0]   IDLE_BA   = 2'b11;
    localparam logic [ADDR_W-1:0] IDLE_ADDR = 13'h1fff;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_INIT  = 3'd0;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd1;
    localparam logic [ST_W-1:0] ST_AREF  = 3'd2;
    localparam logic [ST_W-1:0] ST_WRITE = 3'd3;
    localparam logic [ST_W-1:0] ST_READ  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sdram_arbit.sv
// ============================================================================
// Module      : sdram_arbit
// Description : Grants the shared SDRAM bus to init/refresh/write/read and
//               muxes the owner's command, bank, address and write data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int               CNT_W     = 10,
    parameter logic [CNT_W-1:0] MAX_GRANT = 10'd1000
) (
    input  logic              arb_clk,
    input  logic              arb_rst,
    input  logic              init_end,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [BA_W-1:0]   init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ar_req,
    input  logic              ar_end,
    input  logic [CMD_W-1:0]  ar_cmd,
    input  logic [BA_W-1:0]   ar_bank,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [BA_W-1:0]   wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_dq_oe,
    input  logic [DQ_W-1:0]   wr_dq,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [BA_W-1:0]   rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              ar_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [CMD_W-1:0]  sdram_cmd,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_dq_oe,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              arb_timeout
);

    localparam logic [CNT_W-1:0] C_GRANT_LAST = MAX_GRANT - 1'b1;

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic             r_last_wr;
    logic [CNT_W-1:0] r_cnt_grant;
    logic             r_timeout;
    logic             w_timeout_hit;
    logic             w_wr_done;
    logic             w_rd_done;
    logic             w_granted;
    logic             w_end_hit;

    // State register, round-robin flag and grant watchdog
    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            r_state     <= ST_INIT;
            r_last_wr   <= 1'b0;
            r_cnt_grant <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= w_timeout_hit;
            if (w_granted && (w_state_nxt == r_state)) begin
                r_cnt_grant <= r_cnt_grant + 1'b1;
            end else begin
                r_cnt_grant <= '0;
            end
            if (w_wr_done) begin
                r_last_wr <= 1'b1;
            end else if (w_rd_done) begin
                r_last_wr <= 1'b0;
            end
        end
    end

    // Next-state logic; losing init_end overrides every other transition
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_hit = 1'b0;
        w_wr_done     = 1'b0;
        w_rd_done     = 1'b0;
        w_granted     = (r_state == ST_AREF) || (r_state == ST_WRITE) ||
                        (r_state == ST_READ);
        w_end_hit     = ((r_state == ST_AREF)  && ar_end) ||
                        ((r_state == ST_WRITE) && wr_end) ||
                        ((r_state == ST_READ)  && rd_end);
        if ((r_state != ST_INIT) && !init_end) begin
            w_state_nxt = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (init_end) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (ar_req) begin
                        w_state_nxt = ST_AREF;
                    end else if (wr_req && rd_req) begin
                        w_state_nxt = r_last_wr ? ST_READ : ST_WRITE;
                    end else if (wr_req) begin
                        w_state_nxt = ST_WRITE;
                    end else if (rd_req) begin
                        w_state_nxt = ST_READ;
                    end
                end
                ST_AREF, ST_WRITE, ST_READ: begin
                    if (w_end_hit) begin
                        w_state_nxt = ST_IDLE;
                        w_wr_done   = (r_state == ST_WRITE);
                        w_rd_done   = (r_state == ST_READ);
                    end else if (r_cnt_grant == C_GRANT_LAST) begin
                        w_state_nxt   = ST_IDLE;
                        w_timeout_hit = 1'b1;
                    end
                end
                default: w_state_nxt = ST_INIT;
            endcase
        end
    end

    // Grant enables and bus mux, decoded from the state register only
    always_comb begin
        ar_en        = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        sdram_cmd    = CMD_NOP;
        sdram_ba     = IDLE_BA;
        sdram_addr   = IDLE_ADDR;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = '0;
        case (r_state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_bank;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                ar_en      = 1'b1;
                sdram_cmd  = ar_cmd;
                sdram_ba   = ar_bank;
                sdram_addr = ar_addr;
            end
            ST_WRITE: begin
                wr_en        = 1'b1;
                sdram_cmd    = wr_cmd;
                sdram_ba     = wr_bank;
                sdram_addr   = wr_addr;
                sdram_dq_oe  = wr_dq_oe;
                sdram_dq_out = wr_dq;
            end
            ST_READ: begin
                rd_en      = 1'b1;
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_bank;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign arb_timeout = r_timeout;

endmodule

`default_nettype wire
